// File: rtl/vga_pkg.sv
// Shared definitions for the VGA plot scheduler slice.
//   - screen geometry (SCREEN_W x SCREEN_H) and coordinate/colour widths
//   - scheduler state enum
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int XW       = 8;
    localparam int YW       = 7;
    localparam int CW       = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vga_plot_scheduler_if.sv
// Handshake/bus bundle between the requesters and the plot scheduler.
//   pix_*   : single-pixel request port (req held until pix_ack)
//   fill_*  : rectangle-fill request port (req held until fill_ack)
//   vga_*   : adapter write port (x/y/colour/plot)
// Optional macro VGA_PLOT_SCHEDULER_ABORT_EN adds fill_abort.
// modport slave  : the scheduler side
// modport master : the requester/adapter side
interface vga_plot_scheduler_if #(
    parameter int XW = vga_pkg::XW,
    parameter int YW = vga_pkg::YW,
    parameter int CW = vga_pkg::CW
);
    logic          pix_req;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [CW-1:0] pix_colour;
    logic          pix_ack;

    logic          fill_req;
    logic [XW-1:0] fill_x0;
    logic [YW-1:0] fill_y0;
    logic [XW-1:0] fill_x1;
    logic [YW-1:0] fill_y1;
    logic [CW-1:0] fill_colour;
    logic          fill_ack;
    logic          fill_busy;
    logic          fill_done;
`ifdef VGA_PLOT_SCHEDULER_ABORT_EN
    logic          fill_abort;
`endif

    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;

    modport slave (
        input  pix_req, pix_x, pix_y, pix_colour,
        input  fill_req, fill_x0, fill_y0, fill_x1, fill_y1, fill_colour,
`ifdef VGA_PLOT_SCHEDULER_ABORT_EN
        input  fill_abort,
`endif
        output pix_ack, fill_ack, fill_busy, fill_done,
        output vga_x, vga_y, vga_colour, vga_plot
    );

    modport master (
        output pix_req, pix_x, pix_y, pix_colour,
        output fill_req, fill_x0, fill_y0, fill_x1, fill_y1, fill_colour,
`ifdef VGA_PLOT_SCHEDULER_ABORT_EN
        output fill_abort,
`endif
        input  pix_ack, fill_ack, fill_busy, fill_done,
        input  vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/vga_rect_cursor.sv
// Row-major rectangle walker for the fill engine.
//   load        : latch x0/x1c/y1c, cursor <- (x0,y0)
//   step        : advance cursor one pixel, x fastest, wrapping to x0
//   cur_x/cur_y : current pixel
//   last        : cursor sits on (x1c,y1c)
// Bounds arrive already clipped, so x never exceeds x1c and the y
// increment past y1c (only on the final step) still fits in YW bits.
module vga_rect_cursor
    import vga_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1c,
    input  logic [YW-1:0] y1c,
    input  logic          step,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          last
);

    logic [XW-1:0] x0_q, x1_q, cx_q;
    logic [YW-1:0] y1_q, cy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            cx_q <= '0;
            cy_q <= '0;
        end else if (load) begin
            x0_q <= x0;
            x1_q <= x1c;
            y1_q <= y1c;
            cx_q <= x0;
            cy_q <= y0;
        end else if (step) begin
            if (cx_q == x1_q) begin
                cx_q <= x0_q;
                cy_q <= cy_q + 1'b1;
            end else begin
                cx_q <= cx_q + 1'b1;
            end
        end
    end

    assign cur_x = cx_q;
    assign cur_y = cy_q;
    assign last  = (cx_q == x1_q) && (cy_q == y1_q);

endmodule

// File: rtl/vga_plot_scheduler.sv
// Shares the VGA adapter write port between a single-pixel requester and
// a rectangle-fill engine; one pixel per clock, all outputs registered.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : pix_* / fill_* request ports and vga_* adapter port
// Pixel requests win over fills in IDLE; a fill owns the port until its
// fill_done. Out-of-range pixels are acknowledged but not plotted; fill
// corners are clipped to the screen and empty rectangles plot nothing.
// Optional macro VGA_PLOT_SCHEDULER_ABORT_EN enables bus.fill_abort.
module vga_plot_scheduler
    import vga_pkg::*;
#(
    parameter int X_MAX = SCREEN_W - 1,
    parameter int Y_MAX = SCREEN_H - 1
) (
    input  logic                 clock,
    input  logic                 reset,
    vga_plot_scheduler_if.slave  bus
);

    localparam logic [XW-1:0] X_LIM = XW'(X_MAX);
    localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX);

    state_t        state_q, state_d;
    logic          do_pix, do_fill, fill_step;
    logic          abort_w;
    logic [XW-1:0] x1c, cur_x;
    logic [YW-1:0] y1c, cur_y;
    logic          fill_empty, pix_ok, cur_last;

    logic          pix_ack_q, fill_ack_q, fill_busy_q, fill_done_q, plot_q;
    logic [XW-1:0] vx_q;
    logic [YW-1:0] vy_q;
    logic [CW-1:0] vc_q, fill_col_q;

`ifdef VGA_PLOT_SCHEDULER_ABORT_EN
    assign abort_w = bus.fill_abort;
`else
    assign abort_w = 1'b0;
`endif

    assign x1c        = (bus.fill_x1 > X_LIM) ? X_LIM : bus.fill_x1;
    assign y1c        = (bus.fill_y1 > Y_LIM) ? Y_LIM : bus.fill_y1;
    assign fill_empty = (bus.fill_x0 > x1c) || (bus.fill_y0 > y1c);
    assign pix_ok     = (bus.pix_x <= X_LIM) && (bus.pix_y <= Y_LIM);

    vga_rect_cursor u_cursor (
        .clock (clock),
        .reset (reset),
        .load  (do_fill && !fill_empty),
        .x0    (bus.fill_x0),
        .y0    (bus.fill_y0),
        .x1c   (x1c),
        .y1c   (y1c),
        .step  (fill_step),
        .cur_x (cur_x),
        .cur_y (cur_y),
        .last  (cur_last)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // The pix_ack guard keeps a still-high pix_req from being served twice
    // and lets a waiting fill in on the following edge.
    always_comb begin
        state_d   = state_q;
        do_pix    = 1'b0;
        do_fill   = 1'b0;
        fill_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.pix_req && !pix_ack_q) begin
                    do_pix = 1'b1;
                end else if (bus.fill_req) begin
                    do_fill = 1'b1;
                    state_d = fill_empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (abort_w) begin
                    state_d = DONE;
                end else begin
                    fill_step = 1'b1;
                    if (cur_last) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_ack_q   <= 1'b0;
            fill_ack_q  <= 1'b0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
            plot_q      <= 1'b0;
            vx_q        <= '0;
            vy_q        <= '0;
            vc_q        <= '0;
            fill_col_q  <= '0;
        end else begin
            pix_ack_q   <= do_pix;
            fill_ack_q  <= do_fill;
            fill_done_q <= (state_q == DONE);
            plot_q      <= 1'b0;
            if (do_fill) fill_col_q <= bus.fill_colour;
            // busy covers the ack cycle through the last plot
            if (do_fill && !fill_empty) fill_busy_q <= 1'b1;
            else if (state_q == DONE)   fill_busy_q <= 1'b0;
            // coordinates only move when something is plotted
            if (do_pix && pix_ok) begin
                plot_q <= 1'b1;
                vx_q   <= bus.pix_x;
                vy_q   <= bus.pix_y;
                vc_q   <= bus.pix_colour;
            end else if (fill_step) begin
                plot_q <= 1'b1;
                vx_q   <= cur_x;
                vy_q   <= cur_y;
                vc_q   <= fill_col_q;
            end
        end
    end

    assign bus.pix_ack    = pix_ack_q;
    assign bus.fill_ack   = fill_ack_q;
    assign bus.fill_busy  = fill_busy_q;
    assign bus.fill_done  = fill_done_q;
    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = vx_q;
    assign bus.vga_y      = vy_q;
    assign bus.vga_colour = vc_q;

endmodule
